// File: rtl/acoustic_buf_pkg.sv
// Shared types and default parameters for the acoustic frame buffer.
package acoustic_buf_pkg;

  localparam int unsigned STRIDE_W      = 4;
  localparam int unsigned DEF_DATA_W    = 10;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_FRAME_LEN = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

  // A zero stride means "every sample".
  function automatic logic [STRIDE_W-1:0] eff_stride(input logic [STRIDE_W-1:0] s);
    return (s == '0) ? STRIDE_W'(1) : s;
  endfunction

endpackage

// File: rtl/sample_ring_ram.sv
// Simple dual-port RAM, synchronous read-first port with read enable.
module sample_ring_ram #(
  parameter int unsigned WIDTH  = 40,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Output register is reset so the frame beat reads zero after reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)     rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/acoustic_frame_buffer.sv
// Multi-channel capture ring buffer with strided, backpressured frame readout.
module acoustic_frame_buffer
  import acoustic_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     sample_valid,
  input  logic                     frame_req,
  input  logic [STRIDE_W-1:0]      stride,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     primed,
  output logic                     overrun
);

  localparam int unsigned WORD_W = NUM_CH * DATA_W;
  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);

  rd_state_e state_q, state_d;

  logic                sv_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                primed_q, primed_d;
  logic                overrun_q, overrun_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;

  logic wr_en_c, accept_c, handshake_c, rd_en_c, overrun_hit_c;
  logic [STRIDE_W-1:0] req_stride_c;

  assign wr_en_c      = sample_valid & ~sv_q;
  assign handshake_c  = out_valid_q & out_ready;
  assign req_stride_c = eff_stride(stride);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_req && primed_q) state_d = FETCH;
      FETCH:   state_d = STREAM;
      STREAM:  if (handshake_c && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    rd_en_c  = 1'b0;
    case (state_q)
      IDLE:    accept_c = frame_req & primed_q;
      FETCH:   rd_en_c  = 1'b1;
      STREAM:  rd_en_c  = handshake_c & ~out_last_q;
      default: ;
    endcase
  end

  // A write lands on the next read still waiting to be issued.
  assign overrun_hit_c = wr_en_c && (state_q != IDLE) && !rd_en_c &&
                         (issue_cnt_q != CNT_W'(FRAME_LEN)) && (wr_ptr_q == rd_addr_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    primed_d    = primed_q;
    overrun_d   = overrun_q;
    stride_d    = stride_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (wr_ptr_q == ADDR_W'(DEPTH - 1)) primed_d = 1'b1;
    end

    if (accept_c) begin
      stride_d    = req_stride_c;
      rd_addr_d   = wr_ptr_q - ADDR_W'(FRAME_LEN * 32'(req_stride_c));
      issue_cnt_d = '0;
      overrun_d   = 1'b0;
    end else if (overrun_hit_c) begin
      overrun_d = 1'b1;
    end

    if (rd_en_c) begin
      rd_addr_d   = rd_addr_q + ADDR_W'(stride_q);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
      out_valid_d = 1'b1;
      out_last_d  = (issue_cnt_q == CNT_W'(FRAME_LEN - 1));
    end else if (handshake_c) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sv_q        <= 1'b0;
      wr_ptr_q    <= '0;
      primed_q    <= 1'b0;
      overrun_q   <= 1'b0;
      stride_q    <= STRIDE_W'(1);
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sv_q        <= sample_valid;
      wr_ptr_q    <= wr_ptr_d;
      primed_q    <= primed_d;
      overrun_q   <= overrun_d;
      stride_q    <= stride_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  sample_ring_ram #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset_b   (reset_b),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_data),
    .rd_en_i   (rd_en_c),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign primed    = primed_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_acoustic_frame_buffer.sv
// Self-checking bench: directed vector table, corner sequences, random frames vs. a ring model.
module tb_acoustic_frame_buffer;

  localparam int DW = 10;
  localparam int AW = 4;
  localparam int NC = 2;
  localparam int FL = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset_b;
  logic [NC*DW-1:0] sample_data;
  logic          sample_valid;
  logic          frame_req;
  logic [3:0]    stride;
  logic [NC*DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          primed;
  logic          overrun;

  acoustic_frame_buffer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .reset_b(reset_b), .sample_data(sample_data), .sample_valid(sample_valid),
    .frame_req(frame_req), .stride(stride), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .primed(primed), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [7:0]       nwr;
    logic [3:0]       s;
    logic [15:0]      pat;
    logic [3:0][9:0]  exp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  logic [NC*DW-1:0] mem_m [DEPTH];
  logic [NC*DW-1:0] exp_b [FL];
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] smp(input int i);
    return {10'(100 + i), 10'(i)};
  endfunction

  function automatic vec_t mkv(input int nwr, input int s, input logic [15:0] pat,
                               input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.nwr = 8'(nwr);
    v.s   = 4'(s);
    v.pat = pat;
    v.exp = {10'(e3), 10'(e2), 10'(e1), 10'(e0)};
    return v;
  endfunction

  task automatic do_reset();
    reset_b = 1'b0; sample_valid = 1'b0; frame_req = 1'b0; out_ready = 1'b0;
    stride = 4'd0; sample_data = '0;
    tick(); tick();
    reset_b = 1'b1;
    tick();
    n_wr = 0;
  endtask

  task automatic write_sample(input int hold);
    sample_data = smp(n_wr);
    sample_valid = 1'b1;
    repeat (hold) tick();
    sample_valid = 1'b0;
    mem_m[n_wr % DEPTH] = smp(n_wr);
    n_wr++;
    tick();
  endtask

  // Reference: frame of FL beats ending just before the current write position.
  task automatic model_expect(input int s);
    int se, start;
    se = (s == 0) ? 1 : s;
    start = (((n_wr - FL * se) % DEPTH) + DEPTH) % DEPTH;
    for (int k = 0; k < FL; k++) exp_b[k] = mem_m[(start + k * se) % DEPTH];
  endtask

  task automatic req_ignored(input string name);
    frame_req = 1'b1; stride = 4'($urandom_range(0, 15));
    tick();
    frame_req = 1'b0;
    check({name, "_busy"}, 32'(busy), 0);
    tick();
    check({name, "_valid"}, 32'(out_valid), 0);
  endtask

  task automatic accept_frame(input int s);
    frame_req = 1'b1; stride = 4'(s); out_ready = 1'b0;
    tick();
    frame_req = 1'b0;
    check("acc_busy", 32'(busy), 1);
    check("acc_valid_n1", 32'(out_valid), 0);
    check("acc_overrun_clr", 32'(overrun), 0);
    tick();
    check("acc_valid_n2", 32'(out_valid), 1);
  endtask

  task automatic stream_beats(input logic [15:0] pat, input logic rnd);
    int beats = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [NC*DW-1:0] pd = '0;
    logic pl = 1'b0;
    logic r;
    logic [3:0] ci;
    while (beats < FL && cyc < 200) begin
      if (stalled) begin
        check("hold_data", 32'(out_data), 32'(pd));
        check("hold_last", 32'(out_last), 32'(pl));
      end
      check("valid_held", 32'(out_valid), 1);
      ci = 4'(cyc);
      if (rnd) r = 1'($urandom_range(0, 1));
      else     r = (cyc < 16) ? pat[ci] : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        check("beat_data", 32'(out_data), 32'(exp_b[beats]));
        check("beat_last", 32'(out_last), 32'(beats == FL - 1));
        beats++;
      end
      stalled = out_valid && !r;
      pd = out_data;
      pl = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("beat_count", 32'(beats), FL);
    check("busy_end", 32'(busy), 0);
    check("valid_end", 32'(out_valid), 0);
  endtask

  initial begin
    tbl[0] = mkv(16, 1,  16'hFFFF, 12, 13, 14, 15);
    tbl[1] = mkv(20, 3,  16'hFFFF,  8, 11, 14, 17);
    tbl[2] = mkv(16, 1,  16'hFFE9, 12, 13, 14, 15);
    tbl[3] = mkv(20, 0,  16'hFFFF, 16, 17, 18, 19);
    tbl[4] = mkv(32, 2,  16'hFFFF, 24, 26, 28, 30);
    tbl[5] = mkv(25, 15, 16'h5A5A, 13, 12, 11, 10);

    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_primed", 32'(primed), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_data", 32'(out_data), 0);

    // Not primed after 10 writes: request has no effect.
    repeat (10) write_sample(1);
    req_ignored("unprimed");
    check("unprimed_primed", 32'(primed), 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int w = 0; w < int'(tbl[t].nwr); w++) write_sample(1);
      check("tbl_primed", 32'(primed), 1);
      for (int k = 0; k < FL; k++) exp_b[k] = {10'(10'd100 + tbl[t].exp[k]), tbl[t].exp[k]};
      accept_frame(int'(tbl[t].s));
      stream_beats(tbl[t].pat, 1'b0);
      check("tbl_overrun", 32'(overrun), 0);
    end

    // Stalled frame overwritten by ongoing writes.
    do_reset();
    repeat (16) write_sample(1);
    exp_b[0] = mem_m[12];
    accept_frame(1);
    for (int w = 0; w < 14; w++) begin
      write_sample(1);
      if (w == 12) check("ovr_before", 32'(overrun), 0);
      if (w == 13) check("ovr_set", 32'(overrun), 1);
    end
    for (int k = 1; k < FL; k++) exp_b[k] = mem_m[12 + k];
    stream_beats(16'hFFFF, 1'b0);
    check("ovr_sticky", 32'(overrun), 1);
    model_expect(1);
    accept_frame(1);
    stream_beats(16'hFFFF, 1'b0);

    // Reset during beat 2.
    do_reset();
    repeat (16) write_sample(1);
    model_expect(1);
    accept_frame(1);
    out_ready = 1'b1;
    tick(); tick();
    check("pre_rst_beat2", 32'(out_data), 32'(exp_b[2]));
    reset_b = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_primed", 32'(primed), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    check("mid_rst_data", 32'(out_data), 0);
    out_ready = 1'b0;
    tick();
    reset_b = 1'b1;
    tick();
    n_wr = 0;
    req_ignored("post_rst0");
    repeat (15) write_sample(1);
    req_ignored("post_rst15");
    write_sample(3);
    model_expect(2);
    accept_frame(2);
    stream_beats(16'h0, 1'b1);

    // Random write bursts, strides and backpressure against the ring model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int nw, s;
      nw = $urandom_range(0, 12);
      for (int w = 0; w < nw; w++) write_sample($urandom_range(1, 3));
      s = $urandom_range(0, 15);
      if (n_wr >= DEPTH) begin
        model_expect(s);
        accept_frame(s);
        stream_beats(16'h0, 1'b1);
      end else begin
        req_ignored("rnd_unprimed");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
